// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and command-sequencer states.
package alu_pkg;

  localparam int unsigned OPER_W = 2;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OPER_W-1:0] OP_SUB  = 2'b00;
  localparam logic [OPER_W-1:0] OP_NAND = 2'b01;
  localparam logic [OPER_W-1:0] OP_ONES = 2'b10;
  localparam logic [OPER_W-1:0] OP_DEC  = 2'b11;

  localparam int unsigned FLG_ERR = 0;
  localparam int unsigned FLG_NEG = 1;
  localparam int unsigned FLG_POS = 2;
  localparam int unsigned FLG_OVF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count events, stick at all-ones, clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer in front of the ALU: registers operands, captures the
// ALU result one cycle later and hands it downstream, counting err/ovf events.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [1:0]       i_oper,
  output logic [WIDTH-1:0] o_alu_arg0,
  output logic [WIDTH-1:0] o_alu_arg1,
  output logic [1:0]       o_alu_oper,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [3:0]       i_alu_flag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   capture;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, handshake ready and capture strobe.
  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
        if (i_valid) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        // A new command can only enter when the held response leaves.
        o_ready = i_ready;
        accept  = i_valid & i_ready;
        if (i_ready) begin
          next_state = i_valid ? ISSUE : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand registers toward the ALU; change only on accept.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_alu_arg0 <= '0;
      o_alu_arg1 <= '0;
      o_alu_oper <= '0;
    end else if (accept) begin
      o_alu_arg0 <= i_arg0;
      o_alu_arg1 <= i_arg1;
      o_alu_oper <= i_oper;
    end
  end

  // Response registers: result/flags captured at the end of ISSUE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flag   <= '0;
    end else begin
      o_valid <= (next_state == DONE);
      if (capture) begin
        o_result <= i_alu_result;
        o_flag   <= i_alu_flag;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .clr   (i_clr_cnt),
    .inc   (capture & i_alu_flag[FLG_ERR]),
    .count (o_err_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_cnt (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .clr   (i_clr_cnt),
    .inc   (capture & i_alu_flag[FLG_OVF]),
    .count (o_ovf_cnt)
  );

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command sequencer directly upstream of the ALU top: accepts operand/opcode commands over a valid/ready handshake and registers them onto the ALU inputs. It captures the ALU's combinational result and flags one cycle later and presents them downstream over a second valid/ready handshake. It also keeps saturating error and overflow event counters for software visibility.

## Interface
- WIDTH, 4, operand/result width (matches ALU WIDTH)
- CNT_W, 8, width of each event counter
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  command valid
- o_ready  out  1  command accepted when i_valid & o_ready
- i_arg0, i_arg1  in  WIDTH  operands
- i_oper  in  2  opcode: 00 sub, 01 nand, 10 starting-ones, 11 one-hot→U2 decode
- o_alu_arg0, o_alu_arg1  out  WIDTH  registered operands to ALU
- o_alu_oper  out  2  registered opcode to ALU
- i_alu_result  in  WIDTH  ALU result (combinational from o_alu_*)
- i_alu_flag  in  4  ALU flags: [0] err, [1] neg, [2] pos, [3] overflow
- o_valid  out  1  response valid
- i_ready  in  1  response consumed when o_valid & i_ready
- o_result  out  WIDTH  captured result
- o_flag  out  4  captured flags, same bit order as i_alu_flag
- i_clr_cnt  in  1  synchronous counter clear
- o_err_cnt, o_ovf_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: o_ready=1. On accept, load i_arg0/i_arg1/i_oper into o_alu_*, then go to ISSUE.
- ISSUE: o_ready=0. The ALU settles on the held operands. At the end of the cycle, capture i_alu_result→o_result and i_alu_flag→o_flag, then go to DONE.
- DONE: o_valid=1; o_result/o_flag stay stable until consumed.
  - o_ready = i_ready.
  - Consume with no new accept → IDLE.
  - Consume plus accept in the same cycle → load new operands, go to ISSUE. No bubble beyond the ISSUE cycle.
  - No consume → stay in DONE. An incoming i_valid is not accepted.
- o_alu_* change only on accept and otherwise hold the last command.
- Counters update on the capture edge (ISSUE→DONE):
  - o_err_cnt +1 if captured flag[0].
  - o_ovf_cnt +1 if captured flag[3].
  - Both saturate at 2^CNT_W−1 and never wrap.
- i_clr_cnt=1 zeroes both counters at the next edge. Clear wins over a simultaneous increment.
- Opcode is 2 bits and all four codes are legal; no decode error is generated here.

## Timing
- Reset (async assert, sync-released by the system): state=IDLE, o_ready=1 combinationally, o_valid=0.
- Reset values of o_result, o_flag, o_alu_arg0, o_alu_arg1, o_alu_oper, o_err_cnt, o_ovf_cnt are all 0.
- Latency: accept at edge N → o_alu_* valid after N → capture at edge N+1 → o_valid=1 after N+1.
- Peak throughput: one command per 2 cycles with i_ready held high.
- o_ready depends combinationally on state and i_ready only, never on i_valid.
- o_valid, o_result, o_flag are register outputs.
- Reset mid-operation: any in-flight command is dropped, the FSM returns to IDLE, and counters return to 0.
- i_valid during ISSUE is ignored; the upstream must hold it until o_ready.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_SUB=2'b00, OP_NAND=2'b01, OP_ONES=2'b10, OP_DEC=2'b11
  - flag index constants FLG_ERR=0, FLG_NEG=1, FLG_POS=2, FLG_OVF=3
  - FSM state encoding: IDLE, ISSUE, DONE
- The ALU top also uses alu_pkg for its opcode decode and flag packing.
- One sub-module, sat_counter (params CNT_W; ports clk, rstn, clr, inc, count), instantiated twice.
- ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset then single SUB: arg0=5, arg1=3, oper=00, ALU stub returns result=2, flag=0100 → o_valid exactly 2 edges after accept, o_result=2, o_flag=0100, counters 0.
- Backpressure: i_ready=0 for 5 cycles after o_valid → o_result/o_flag stable, o_ready=0, and a second i_valid is not accepted until consume.
- Back-to-back: i_valid and i_ready held high, 4 commands → one accept every 2 cycles, responses in order, each o_alu_* value stable for the full ISSUE cycle.
- Counter saturation: CNT_W=2, 5 captures with stub flag=1001 → o_err_cnt=3 and o_ovf_cnt=3 after the third capture, remaining at 3. Then i_clr_cnt on a capture edge → both counters 0.
- Async reset asserted mid-ISSUE (i_rstn low between clock edges) → o_valid=0, o_ready=1, and all outputs 0 immediately without waiting for a clock edge. No stale response appears after release.
- Opcode passthrough: accept oper=11, arg0=4'b0100, arg1=4'b0001 → o_alu_oper=11, o_alu_arg0=0100, o_alu_arg1=0001 after the accept edge, with values held until the next accept.
